data_mem_resp: RTL and testbench
================================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning RAM size in 32-bit words (power of two, 4..65536).
REQ-002 SHALL have parameter MMIO_BASE, default 32'hFFFF_0000, meaning the 16-byte-aligned base of the register window.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous reset, active-high.
REQ-005 SHALL have port ce_i  input  1  access request from the CPU data port.
REQ-006 SHALL have port we_i  input  1  1 = store, 0 = load; qualified by ce_i.
REQ-007 SHALL have port addr_i  input  32  byte address.
REQ-008 SHALL have port data_i  input  32  store data from the CPU.
REQ-009 SHALL have port data_o  output  32  load data to the CPU.
REQ-010 SHALL have port err_o  output  1  current access is faulting (combinational).
REQ-011 SHALL have port irq_o  output  1  registered timer-match interrupt.

Function
REQ-012 SHALL decode each access as exactly one of:
- RAM: addr_i < DEPTH*4
- MMIO: addr_i[31:4] == MMIO_BASE[31:4] and addr_i[3:2] != 2'b11
- otherwise a range fault.
REQ-013 SHALL treat addr_i[1:0] != 0 with ce_i=1 as an alignment fault. Alignment takes precedence over range.
REQ-014 SHALL drive err_o = ce_i & (alignment fault | range fault) in the same cycle.
REQ-015 Loads SHALL be zero-latency: data_o SHALL be valid combinationally in the same cycle as ce_i=1, we_i=0.
REQ-016 SHALL drive data_o = 0 when ce_i=0, we_i=1, or err_o=1.
REQ-017 A RAM store (ce_i, we_i, no fault) SHALL write data_i to word addr_i[log2(DEPTH)+1:2] at the clock edge, and SHALL set that word's valid bit.
REQ-018 A RAM load of a word whose valid bit is 0 SHALL return 0.
REQ-019 A load from a word stored in the same cycle SHALL return the old contents; the new value is visible from the next cycle.
REQ-020 Faulting stores SHALL modify no state other than the STATUS fields (REQ-025).
REQ-021 MMIO offset 0x0, CYCLE: read-only; increments by 1 every cycle and wraps 0xFFFFFFFF->0; stores to it are ignored without fault.
REQ-022 MMIO offset 0x4, CMP: read/write.
REQ-023 MMIO offset 0x8, STATUS:
- bit0 = sticky alignment fault
- bit1 = sticky range fault
- bits[15:8] = fault count, saturating at 255
- other bits read 0.
REQ-024 A store to STATUS SHALL be write-1-to-clear for bits 1:0; data_i[31]=1 SHALL clear the count.
REQ-025 Each faulting access SHALL set its sticky bit and increment the count (saturating) at the clock edge.
REQ-026 irq_o SHALL set at the edge where CYCLE == CMP, and SHALL clear on any store to CMP.
REQ-027 If a CMP store and a match occur on the same edge, the store SHALL win and irq_o SHALL be 0.
REQ-028 irq_o SHALL otherwise hold until cleared.

Reset
REQ-029 While rst=1, all state SHALL clear immediately and asynchronously: CYCLE=0, CMP=32'hFFFFFFFF, STATUS=0, irq_o=0, all valid bits=0.
REQ-030 RAM array contents SHALL not be reset.
REQ-031 Any store coinciding with rst=1 SHALL be discarded.
REQ-032 Outputs during reset SHALL be: data_o=0, err_o=ce_i & fault (combinational).
REQ-033 CYCLE SHALL first read 1 one cycle after rst deasserts.

Structure
REQ-034 A shared package SHALL hold:
- MMIO offsets CYCLE/CMP/STATUS
- STATUS bit positions
- the fault-count width (8)
- the CMP reset value.
REQ-035 The CYCLE/CMP/irq logic SHALL be one sub-module, dmem_timer. The RAM, valid bitmap, decode and STATUS SHALL stay in data_mem_resp.

Verification
REQ-036 Store 0xDEADBEEF to 0x10, then load 0x10 next cycle -> data_o=0xDEADBEEF, err_o=0. Load 0x14 (never written) -> data_o=0.
REQ-037 Store to 0x3 -> err_o=1 that cycle, RAM unchanged. STATUS read -> 0x0000_0101. Store 0x3 to STATUS -> next STATUS read has bits[1:0]=0 and count=1.
REQ-038 Load DEPTH*4 and load MMIO_BASE+0xC -> err_o=1, data_o=0, STATUS bit1=1, count=2. Then 300 faults -> count saturates at 255.
REQ-039 Deassert rst, store CMP=20 -> irq_o rises at the edge where CYCLE==20. A store to CMP coinciding with that match edge -> irq_o stays 0.
REQ-040 Store word 0x20, then assert rst mid-run -> valid bits clear, so load 0x20 returns 0. CYCLE, STATUS and irq_o read 0; CMP reads 0xFFFFFFFF.

Source files
------------

// File: rtl/data_mem_resp_pkg.sv
// Shared definitions for the data-memory responder: register-window layout,
// STATUS field positions and reset constants.
package data_mem_resp_pkg;

  localparam logic [3:0] OFF_CYCLE  = 4'h0;
  localparam logic [3:0] OFF_CMP    = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;

  localparam int ST_ALIGN_BIT   = 0;
  localparam int ST_RANGE_BIT   = 1;
  localparam int ST_CNT_LSB     = 8;
  localparam int ST_CLR_CNT_BIT = 31;
  localparam int FCNT_W         = 8;

  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_MMIO,
    REGION_NONE
  } region_e;

  function automatic logic [31:0] status_word(input logic align_f,
                                              input logic range_f,
                                              input logic [FCNT_W-1:0] cnt);
    logic [31:0] w;
    w = '0;
    w[ST_ALIGN_BIT] = align_f;
    w[ST_RANGE_BIT] = range_f;
    w[ST_CNT_LSB +: FCNT_W] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/data_mem_resp_timer.sv
// Free-running cycle counter with a compare register and a sticky match
// interrupt; a compare store on the match edge suppresses the interrupt.
module dmem_timer
  import data_mem_resp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmp_we_i,
  input  logic [31:0] cmp_wdata_i,
  output logic [31:0] cycle_o,
  output logic [31:0] cmp_o,
  output logic        irq_o
);

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] cmp_q, cmp_d;
  logic        irq_q, irq_d;

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    cmp_d   = cmp_we_i ? cmp_wdata_i : cmp_q;
    if (cmp_we_i) begin
      irq_d = 1'b0;
    end else if (cycle_q == cmp_q) begin
      irq_d = 1'b1;
    end else begin
      irq_d = irq_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= '0;
      cmp_q   <= CMP_RST;
      irq_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      cmp_q   <= cmp_d;
      irq_q   <= irq_d;
    end
  end

  assign cycle_o = cycle_q;
  assign cmp_o   = cmp_q;
  assign irq_o   = irq_q;

endmodule

// File: rtl/data_mem_resp.sv
// CPU data-port responder: zero-latency word RAM with per-word valid bits,
// a small register window (cycle timer, compare, fault status) and fault decode.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        err_o,
  output logic        irq_o
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  logic [31:0]       mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic              align_q, align_d;
  logic              range_q, range_d;
  logic [FCNT_W-1:0] cnt_q, cnt_d;

  region_e     region;
  logic        align_f, range_f, ok;
  logic [3:0]  off;
  logic [AW-1:0] idx;
  logic        ram_we, cmp_we, st_we;
  logic [31:0] cycle_v, cmp_v, rdata;

  assign idx = addr_i[AW+1:2];
  assign off = {addr_i[3:2], 2'b00};

  always_comb begin
    region = REGION_NONE;
    if (addr_i < RAM_BYTES) begin
      region = REGION_RAM;
    end else if (addr_i[31:4] == MMIO_BASE[31:4] && addr_i[3:2] != 2'b11) begin
      region = REGION_MMIO;
    end
  end

  // A misaligned access is reported only as an alignment fault, never as range.
  assign align_f = ce_i & (addr_i[1:0] != 2'b00);
  assign range_f = ce_i & ~align_f & (region == REGION_NONE);
  assign err_o   = align_f | range_f;
  assign ok      = ce_i & ~err_o;

  assign ram_we = ok & we_i & (region == REGION_RAM);
  assign cmp_we = ok & we_i & (region == REGION_MMIO) & (off == OFF_CMP);
  assign st_we  = ok & we_i & (region == REGION_MMIO) & (off == OFF_STATUS);

  dmem_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .cmp_we_i    (cmp_we),
    .cmp_wdata_i (data_i),
    .cycle_o     (cycle_v),
    .cmp_o       (cmp_v),
    .irq_o       (irq_o)
  );

  always_ff @(posedge clk) begin
    if (ram_we && !rst) begin
      mem_q[idx] <= data_i;
    end
  end

  always_comb begin
    align_d = align_q;
    range_d = range_q;
    cnt_d   = cnt_q;
    if (st_we) begin
      if (data_i[ST_ALIGN_BIT])   align_d = 1'b0;
      if (data_i[ST_RANGE_BIT])   range_d = 1'b0;
      if (data_i[ST_CLR_CNT_BIT]) cnt_d   = '0;
    end
    if (align_f) align_d = 1'b1;
    if (range_f) range_d = 1'b1;
    if (err_o && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      align_q <= 1'b0;
      range_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (ram_we) valid_q[idx] <= 1'b1;
      align_q <= align_d;
      range_q <= range_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (region == REGION_RAM) begin
      rdata = valid_q[idx] ? mem_q[idx] : '0;
    end else if (region == REGION_MMIO) begin
      case (off)
        OFF_CYCLE:  rdata = cycle_v;
        OFF_CMP:    rdata = cmp_v;
        OFF_STATUS: rdata = status_word(align_q, range_q, cnt_q);
        default:    rdata = '0;
      endcase
    end
  end

  assign data_o = (ok & ~we_i & ~rst) ? rdata : '0;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed scoreboard bench for data_mem_resp: stimulus pushes expectations,
// a negedge monitor pops and compares them.
module tb_data_mem_resp;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        err_o;
  logic        irq_o;

  data_mem_resp dut (
    .clk    (clk),
    .rst    (rst),
    .ce_i   (ce_i),
    .we_i   (we_i),
    .addr_i (addr_i),
    .data_i (data_i),
    .data_o (data_o),
    .err_o  (err_o),
    .irq_o  (irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] d;
    logic        e;
    bit          ci;
    logic        i;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   chk_v = 0;
  logic rst_next = 1'b1;
  int   win = 0;
  int   rel = 0;

  always @(negedge clk) begin
    if (chk_v) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty: monitor saw a checked window with no expectation queued");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (data_o !== e.d || err_o !== e.e || (e.ci && irq_o !== e.i)) begin
          bad++;
          $display("FAIL %s: got data_o=%h err_o=%b irq_o=%b, want data_o=%h err_o=%b irq_o=%b%s",
                   e.nm, data_o, err_o, irq_o, e.d, e.e, e.i, e.ci ? "" : " (irq ignored)");
        end
      end
    end
  end

  task automatic drive(input logic ce, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input bit chk, input logic [31:0] ed,
                       input logic ee, input bit ci, input logic ei, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    win++;
    if (rst && !rst_next) rel = win;
    rst    = rst_next;
    ce_i   = ce;
    we_i   = we;
    addr_i = a;
    data_i = wd;
    chk_v  = chk;
    if (chk) begin
      e.nm = nm; e.d = ed; e.e = ee; e.ci = ci; e.i = ei;
      sb.push_back(e);
    end
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] ed, input logic ee, input string nm);
    drive(1'b1, 1'b0, a, 32'h0, 1'b1, ed, ee, 1'b0, 1'b0, nm);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] wd, input logic ee, input string nm);
    drive(1'b1, 1'b1, a, wd, 1'b1, 32'h0, ee, 1'b0, 1'b0, nm);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "idle");
  endtask

  task automatic irqchk(input logic ei, input string nm);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, ei, nm);
  endtask

  // Idle until the next driven window is the one where CYCLE reads c.
  task automatic goto_cycle(input int c);
    while (win + 1 - rel < c) idle();
  endtask

  task automatic ld_cycle(input string nm);
    ld(MB, 32'(win + 1 - rel), 1'b0, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held from time zero
    ld(32'h0, 32'h0, 1'b0, "rst_ram_zero");
    ld(32'h3, 32'h0, 1'b1, "rst_align_err");
    drive(1'b1, 1'b0, MB + 32'h4, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, "rst_data_gated");
    st(32'h24, 32'h1234, 1'b0, "rst_store");
    rst_next = 1'b0;
    idle();
    ld_cycle("cycle_first_one");
    ld(32'h24, 32'h0, 1'b0, "rst_store_dropped");

    // Timer compare and interrupt
    st(MB + 32'h4, 32'd20, 1'b0, "cmp_store");
    ld(MB + 32'h4, 32'd20, 1'b0, "cmp_read");
    goto_cycle(20);
    irqchk(1'b0, "irq_before_match");
    drive(1'b1, 1'b0, MB, 32'h0, 1'b1, 32'd21, 1'b0, 1'b1, 1'b1, "irq_set");
    goto_cycle(30);
    st(MB + 32'h4, 32'd40, 1'b0, "cmp_store2");
    irqchk(1'b0, "irq_cleared_by_store");
    goto_cycle(40);
    st(MB + 32'h4, 32'd100, 1'b0, "cmp_store_on_match");
    irqchk(1'b0, "irq_store_wins");

    // RAM and valid bits
    st(32'h10, 32'hDEAD_BEEF, 1'b0, "ram_store");
    ld(32'h10, 32'hDEAD_BEEF, 1'b0, "ram_load");
    ld(32'h14, 32'h0, 1'b0, "ram_unwritten");

    // Faults and STATUS
    st(32'h3, 32'h55, 1'b1, "align_store_err");
    ld(32'h0, 32'h0, 1'b0, "align_ram_unchanged");
    ld(MB + 32'h8, 32'h0000_0101, 1'b0, "status_101");
    st(MB + 32'h8, 32'h3, 1'b0, "status_w1c");
    ld(MB + 32'h8, 32'h0000_0100, 1'b0, "status_cnt_kept");
    st(MB + 32'h8, 32'h8000_0000, 1'b0, "status_clr_cnt");
    ld(MB + 32'h8, 32'h0, 1'b0, "status_zero");
    ld(32'h1000, 32'h0, 1'b1, "range_ram_end");
    ld(MB + 32'hC, 32'h0, 1'b1, "range_mmio_hole");
    st(32'h1000, 32'h0BAD, 1'b1, "range_store_err");
    ld(32'h0, 32'h0, 1'b0, "range_store_no_write");
    ld(MB + 32'h8, 32'h0000_0302, 1'b0, "status_range");
    st(MB, 32'h55, 1'b0, "cycle_store_ignored");
    ld_cycle("cycle_after_store");
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b0, 32'h2, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "flood");
    end
    ld(MB + 32'h8, 32'h0000_FF03, 1'b0, "status_saturated");
    st(MB + 32'h8, 32'h3, 1'b0, "status_w1c2");
    ld(32'h1001, 32'h0, 1'b1, "align_over_range");
    ld(MB + 32'h8, 32'h0000_FF01, 1'b0, "status_precedence");

    // Reset mid-run
    st(32'h20, 32'hCAFE_F00D, 1'b0, "ram_store2");
    ld(32'h20, 32'hCAFE_F00D, 1'b0, "ram_load2");
    drive(1'b1, 1'b0, MB + 32'h4, 32'h0, 1'b1, 32'd100, 1'b0, 1'b1, 1'b1, "irq_before_rst");
    rst_next = 1'b1;
    drive(1'b1, 1'b0, 32'h1, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, "rst_async_clear");
    rst_next = 1'b0;
    ld(MB, 32'h0, 1'b0, "rst_cycle_zero");
    ld(32'h20, 32'h0, 1'b0, "rst_valid_cleared");
    ld(MB + 32'h8, 32'h0, 1'b0, "rst_status_zero");
    drive(1'b1, 1'b0, MB + 32'h4, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0,
          "rst_cmp_value");
    idle();

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      bad++;
      total++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
